// File: rtl/cmp_arbiter_if.sv
// Bundle between the two compare requesters, the shared comparator and cmp_arbiter.
// The master side is the requester/comparator environment; the slave side is the arbiter.
interface cmp_arbiter_if;
  logic        req0;
  logic [31:0] rs1_0;
  logic [31:0] rs2_0;
  logic [2:0]  op0;
  logic        req1;
  logic [31:0] rs1_1;
  logic [31:0] rs2_1;
  logic [2:0]  op1;
  logic        gnt0;
  logic        gnt1;
  logic [31:0] cmp_rs1;
  logic [31:0] cmp_rs2;
  logic [2:0]  cmp_op;
  logic        cmp_out;
  logic        valid0;
  logic        valid1;
  logic        res0;
  logic        res1;

  modport master (
    output req0, rs1_0, rs2_0, op0, req1, rs1_1, rs2_1, op1, cmp_out,
    input  gnt0, gnt1, cmp_rs1, cmp_rs2, cmp_op, valid0, valid1, res0, res1
  );

  modport slave (
    input  req0, rs1_0, rs2_0, op0, req1, rs1_1, rs2_1, op1, cmp_out,
    output gnt0, gnt1, cmp_rs1, cmp_rs2, cmp_op, valid0, valid1, res0, res1
  );
endinterface

// File: rtl/cmp_arbiter.sv
// Two-port arbiter sharing one branch/SLT comparator between the branch unit (port 0)
// and the SLT/SLTU path (port 1); results come back in a per-port registered slot.
module cmp_arbiter #(
  parameter bit RR = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  cmp_arbiter_if.slave  bus
);

  logic        last_r;
  logic        valid0_r;
  logic        valid1_r;
  logic        res0_r;
  logic        res1_r;
  logic        gnt0_s;
  logic        gnt1_s;
  logic [31:0] cmp_rs1_s;
  logic [31:0] cmp_rs2_s;
  logic [2:0]  cmp_op_s;

  // Grant selection: on contention the port that did not win last time goes first.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (rst) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else begin
      case ({bus.req1, bus.req0})
        2'b01: gnt0_s = 1'b1;
        2'b10: gnt1_s = 1'b1;
        2'b11: begin
          if (RR && (last_r == 1'b0)) begin
            gnt1_s = 1'b1;
          end else begin
            gnt0_s = 1'b1;
          end
        end
        default: begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      endcase
    end
  end

  // Operand steering; an idle comparator sees all-zero inputs.
  always_comb begin
    cmp_rs1_s = 32'd0;
    cmp_rs2_s = 32'd0;
    cmp_op_s  = 3'd0;
    case ({gnt1_s, gnt0_s})
      2'b01: begin
        cmp_rs1_s = bus.rs1_0;
        cmp_rs2_s = bus.rs2_0;
        cmp_op_s  = bus.op0;
      end
      2'b10: begin
        cmp_rs1_s = bus.rs1_1;
        cmp_rs2_s = bus.rs2_1;
        cmp_op_s  = bus.op1;
      end
      default: begin
        cmp_rs1_s = 32'd0;
        cmp_rs2_s = 32'd0;
        cmp_op_s  = 3'd0;
      end
    endcase
  end

  // Result slots and round-robin history; LAST resets to 1 so port 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r   <= 1'b1;
      valid0_r <= 1'b0;
      valid1_r <= 1'b0;
      res0_r   <= 1'b0;
      res1_r   <= 1'b0;
    end else begin
      valid0_r <= gnt0_s;
      valid1_r <= gnt1_s;
      if (gnt0_s) begin
        res0_r <= bus.cmp_out;
        last_r <= 1'b0;
      end else if (gnt1_s) begin
        res1_r <= bus.cmp_out;
        last_r <= 1'b1;
      end else begin
        last_r <= last_r;
      end
    end
  end

  assign bus.gnt0    = gnt0_s;
  assign bus.gnt1    = gnt1_s;
  assign bus.cmp_rs1 = cmp_rs1_s;
  assign bus.cmp_rs2 = cmp_rs2_s;
  assign bus.cmp_op  = cmp_op_s;
  assign bus.valid0  = valid0_r;
  assign bus.valid1  = valid1_r;
  assign bus.res0    = res0_r;
  assign bus.res1    = res1_r;

endmodule

// File: doc/cmp_arbiter.md
# cmp_arbiter

Two-port round-robin arbiter that time-shares the single branch/set-less-than comparator between two requesters, the branch unit (port 0) and the SLT/SLTU ALU path (port 1). Each cycle it grants at most one request, steers that request's operands and opcode onto the comparator, and returns the 1-bit result to the granted port in a registered result slot one cycle later. It sits between the decode/execute control and the comparator instance in the execute stage.

## Interface
- RR, default 1: 1 = round-robin between ports; 0 = fixed priority, port 0 always wins.
- CLK  in  1  system clock, all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ0  in  1  port 0 request.
- RS1_0  in  32  port 0 first operand.
- RS2_0  in  32  port 0 second operand.
- OP0  in  3  port 0 compare opcode, `ALU_EQ`/`ALU_NE`/`ALU_LT`/`ALU_GE`/`ALU_LTU`/`ALU_GEU` from defs.v.
- REQ1, RS1_1, RS2_1, OP1  in  1/32/32/3  port 1 equivalents.
- GNT0, GNT1  out  1  combinational grant; at most one high per cycle.
- CMP_RS1, CMP_RS2  out  32  operands steered to the comparator.
- CMP_OP  out  3  opcode steered to the comparator.
- CMP_OUT  in  1  comparator result, combinational from CMP_RS1/CMP_RS2/CMP_OP.
- VALID0, VALID1  out  1  one-cycle pulse: RESn holds a new result.
- RES0, RES1  out  1  registered result per port, held until that port's next result.

## Operation
- State: LAST (1 bit, index of the most recently granted port), VALID0/1, RES0/1.
- Grant logic (combinational, forced 0 while RST=1):
  - Only REQ0: GNT0=1. Only REQ1: GNT1=1. Neither: no grant.
  - Both, RR=1: grant the port ≠ LAST. Both, RR=0: GNT0=1.
- Steering: GNT0 → CMP_* = RS1_0/RS2_0/OP0. GNT1 → port 1 fields. No grant → CMP_RS1=0, CMP_RS2=0, CMP_OP=0.
- Opcode is passed through unmodified. The arbiter neither decodes nor checks it.
- On a rising edge with grant to port n:
  - RESn ← CMP_OUT.
  - VALIDn ← 1.
  - LAST ← n. LAST is updated in both RR modes.
- On a rising edge where port n is not granted: VALIDn ← 0 and RESn holds.
- Requester rule: hold REQn and its operands stable until GNTn is sampled high. Dropping REQn before the grant withdraws the request with no side effects. REQn high in the cycle after a grant is a new, independent request.
- Reset (RST=1 on an edge):
  - LAST ← 1, so port 0 wins the first contention.
  - VALID0/1 ← 0, RES0/1 ← 0.
  - Any request present that cycle is not granted, and no result is produced for it.

## Timing
- Grant latency: 0 cycles. GNTn is valid in the same cycle REQn is presented, if it wins.
- Result latency: 1 cycle. The result for a grant in cycle t appears on RESn with VALIDn=1 in cycle t+1.
- Throughput: one compare per cycle in total, shared across both ports.
- Worst-case wait under continuous contention:
  - RR=1: 1 cycle, with strict alternation 0,1,0,1… starting with port 0 after reset.
  - RR=0: port 1 starves while REQ0 is held high. This is intended for debug only.
- Back-to-back grants to the same port (other port idle): VALIDn stays high on consecutive cycles and RESn updates every cycle.
- RST asserted mid-stream: a result registered on the previous edge is lost at the reset edge. Outputs read 0 from the first cycle after the reset edge.

## Test plan
- Reset: hold RST=1 two cycles with REQ0=REQ1=1 → GNT0=GNT1=0 throughout; VALID0/1=0, RES0/1=0. First post-reset cycle with both requesting → GNT0=1.
- Single port 0: REQ0=1, RS1_0=32'hFFFFFFFF, RS2_0=1, OP0=`ALU_LT` → same cycle GNT0=1, CMP_RS1=32'hFFFFFFFF. Next cycle VALID0=1, RES0=1, VALID1=0. Repeat with `ALU_LTU` → RES0=0.
- Contention, RR=1: both request continuously for 4 cycles; port 0 `ALU_EQ` 5,5; port 1 `ALU_GEU` 3,7.
  - Required grants: 0,1,0,1.
  - Required results: RES0=1 pulsed in cycles 2 and 4, RES1=0 pulsed in cycles 3 and 5.
  - RES values hold between pulses.
- Fixed priority, RR=0: both request for 3 cycles → GNT0 every cycle, GNT1 never. Drop REQ0 → GNT1 in the same cycle, VALID1 the next cycle.
- Idle: no requests → CMP_RS1=CMP_RS2=0, CMP_OP=0, VALID pulses clear after one cycle, and RES0/RES1 retain their last values.
- Reset mid-operation: grant port 1 in cycle t, then RST=1 at the edge ending cycle t+1 → after that edge VALID1=0, RES1=0, LAST=1. The next contention grants port 0.
